// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM for the multicycle MIPS datapath.
// Sequences mux selects and write enables per instruction: FETCH -> DECODE -> exec/mem/writeback.
// Optional build macro MEM_WAIT_EN: adds mem_ready; FETCH, MEMRD and MEMWR stall until it is high.
module multicycle_ctrl_fsm #(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned ALUOP_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic                   zero,
`ifdef MEM_WAIT_EN
  input  logic                   mem_ready,
`endif
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_src,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   instr_done
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(2'b00);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(2'b01);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2'b10);

  logic [3:0] state;
  logic [3:0] state_next;
  logic       is_load;
  logic       mem_ok;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // State register; remembers lw vs sw at DECODE since opcode is only trusted there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      is_load <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        is_load <= (opcode == OP_LW);
      end
    end
  end

  // Next-state and Moore output decode; reset forces FETCH selects with all enables low.
  always_comb begin
    state_next = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    if (rst) begin
      alu_src_b = 2'b01;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          if (mem_ok) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end else begin
            state_next = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = ALU_ADD;
          case (opcode)
            OP_R:         state_next = S_EXEC;
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_J:         state_next = S_JUMP;
            default: begin
              state_next = S_FETCH;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          state_next = is_load ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read   = 1'b1;
          iord       = 1'b1;
          state_next = mem_ok ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ok;
          state_next = mem_ok ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b00;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_op     = ALU_ADD;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed then random stimulus against a queue-of-control-words model.
// Each instruction is expanded into its expected per-cycle control words; one is consumed per cycle.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  typedef enum int {K_PLAIN, K_FETCH, K_MEM, K_DEC, K_BR} kind_t;

  typedef struct {
    kind_t k;
    ctrl_t c;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done;
  logic [1:0] alu_src_b, pc_src, alu_op;
  ctrl_t      obs;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [5:0] dec_op = 6'b000000;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .instr_done (instr_done)
  );

  assign obs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, instr_done};

  // Cycles from fetch to instr_done for a single-cycle memory.
  function automatic int exp_lat(input logic [5:0] op);
    case (op)
      6'b100011:                     return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:          return 3;
      default:                       return 2;
    endcase
  endfunction

  // One row of the control table:   pcw irw iord mr mw rw rd m2r asa asb pcs aop done
  function automatic step_t mk(input kind_t k, input bit pcw, input bit irw, input bit io,
                               input bit mr, input bit mw, input bit rw, input bit rd,
                               input bit m2r, input bit asa, input logic [1:0] asb,
                               input logic [1:0] pcs, input logic [1:0] aop, input bit done);
    step_t s;
    s.k = k;
    s.c = {pcw, irw, io, mr, mw, rw, rd, m2r, asa, asb, pcs, aop, done};
    return s;
  endfunction

  // Expected words after DECODE, by instruction.
  task automatic expand(input logic [5:0] op);
    case (op)
      6'b100011: begin
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0));
        q.push_back(mk(K_MEM,   0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0));
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1));
      end
      6'b101011: begin
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0));
        q.push_back(mk(K_MEM,   0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 1));
      end
      6'b000000: begin
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10, 0));
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 1));
      end
      6'b000100:
        q.push_back(mk(K_BR,    0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1));
      6'b001000: begin
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0));
        q.push_back(mk(K_PLAIN, 0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 1));
      end
      6'b000010:
        q.push_back(mk(K_PLAIN, 1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 1));
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, check the outputs against the model, then advance the model.
  task automatic cycle(input logic [5:0] op, input logic z, input logic r, input logic mr);
    step_t s;
    ctrl_t e;
    bit    hold;
    int    lat;
    @(negedge clk);
    opcode    = op;
    zero      = z;
    rst       = r;
    mem_ready = mr;
    #1;
    if (q.size() == 0) begin
      q.push_back(mk(K_FETCH, 1,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0));
      q.push_back(mk(K_DEC,   0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0));
      start_cyc = cyc;
    end
    s    = q[0];
    e    = s.c;
    hold = 1'b0;
    if (r) begin
      e = '0;
      e.alu_src_b = 2'b01;
    end else begin
      case (s.k)
        K_FETCH: if (!mem_ready) begin
          e.pc_write = 1'b0;
          e.ir_write = 1'b0;
          hold = 1'b1;
        end
        K_MEM: if (!mem_ready) begin
          e.instr_done = 1'b0;
          hold = 1'b1;
        end
        K_DEC: begin
          dec_op = op;
          if (exp_lat(op) == 2) e.instr_done = 1'b1;
        end
        K_BR: e.pc_write = z;
        default: ;
      endcase
    end
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL ctrl cyc=%0d op=%b rst=%b zero=%b observed=%h expected=%h", cyc, op, r, z, obs, e);
    end
`ifndef MEM_WAIT_EN
    if (!r && obs.instr_done === 1'b1) begin
      lat = cyc - start_cyc + 1;
      tests++;
      assert (lat === exp_lat(dec_op)) else begin
        fails++;
        $error("FAIL latency cyc=%0d op=%b observed=%0d expected=%0d", cyc, dec_op, lat, exp_lat(dec_op));
      end
    end
`endif
    if (r) begin
      q.delete();
    end else if (!hold) begin
      void'(q.pop_front());
      if (s.k == K_DEC) expand(op);
    end
    cyc++;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] r;
    r = 6'($urandom);
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b111111;
      default: return r;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    repeat (3) cycle(6'b000000, 1'b0, 1'b1, 1'b1);
    repeat (5) cycle(6'b100011, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(6'b000100, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(6'b000100, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(6'b000000, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(6'b001000, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(6'b111111, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(6'b100011, 1'b0, 1'b0, 1'b1);
    cycle(6'b100011, 1'b0, 1'b1, 1'b1);
    repeat (2) cycle(6'b101011, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(6'b101011, 1'b0, 1'b0, 1'b1);
`ifdef MEM_WAIT_EN
    repeat (3) cycle(6'b101011, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(6'b101011, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(6'b101011, 1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 800; i++) begin
`ifdef MEM_WAIT_EN
      cycle(rand_op(), 1'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
`else
      cycle(rand_op(), 1'($urandom), ($urandom_range(0, 39) == 0), 1'b1);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
